// File: rtl/arm_mc_controller.sv
// Multicycle control unit for the ARMv4-subset core.
// This block sequences Fetch/Decode/Execute/Writeback over a shared memory and ALU.
// It also owns the NZCV flag register and the latched condition-execute bit.
module arm_mc_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [19:0]        Instr,
  input  logic [3:0]         ALUFlags,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic               MovFlag,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_flags;
  logic        r_condex;

  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_rd15;
  logic        w_unused_rn;

  logic [1:0]  w_aluctl;
  logic        w_dp_valid;
  logic        w_cmp;
  logic        w_mov;
  logic        w_cv;

  logic        w_pcw;
  logic        w_irw;
  logic        w_mw;
  logic        w_rw;

  assign w_cond      = Instr[19:16];
  assign w_op        = Instr[15:14];
  assign w_funct     = Instr[13:8];
  assign w_rd15      = (Instr[3:0] == 4'hF);
  assign w_unused_rn = &{1'b0, Instr[7:4]};

  // ARM condition-field evaluation against {N,Z,C,V}; 1111 never executes
  function automatic logic f_condcheck(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: f_condcheck = z;
      4'b0001: f_condcheck = ~z;
      4'b0010: f_condcheck = c;
      4'b0011: f_condcheck = ~c;
      4'b0100: f_condcheck = n;
      4'b0101: f_condcheck = ~n;
      4'b0110: f_condcheck = v;
      4'b0111: f_condcheck = ~v;
      4'b1000: f_condcheck = c & ~z;
      4'b1001: f_condcheck = ~c | z;
      4'b1010: f_condcheck = (n == v);
      4'b1011: f_condcheck = (n != v);
      4'b1100: f_condcheck = ~z & (n == v);
      4'b1101: f_condcheck = z | (n != v);
      4'b1110: f_condcheck = 1'b1;
      default: f_condcheck = 1'b0;
    endcase
  endfunction

  // Data-processing command decode; unlisted commands are invalid and write nothing
  always_comb begin
    w_aluctl   = 2'b00;
    w_dp_valid = 1'b0;
    w_cmp      = 1'b0;
    w_mov      = 1'b0;
    w_cv       = 1'b0;
    case (w_funct[4:1])
      4'b0100: begin w_dp_valid = 1'b1; w_aluctl = 2'b00; w_cv = 1'b1; end
      4'b0010: begin w_dp_valid = 1'b1; w_aluctl = 2'b01; w_cv = 1'b1; end
      4'b0000: begin w_dp_valid = 1'b1; w_aluctl = 2'b10; end
      4'b1100: begin w_dp_valid = 1'b1; w_aluctl = 2'b11; end
      4'b1010: begin w_dp_valid = 1'b1; w_aluctl = 2'b01; w_cmp = 1'b1; w_cv = 1'b1; end
      4'b1101: begin w_dp_valid = 1'b1; w_mov = 1'b1; end
      default: ;
    endcase
  end

  // State register; reset returns straight to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // CondExR latched in DECODE; flags updated at the end of an executed DP/CMP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags  <= 4'b0000;
      r_condex <= 1'b0;
    end else begin
      if (r_state == S_DECODE)
        r_condex <= f_condcheck(w_cond, r_flags);
      if (((r_state == S_EXECR) || (r_state == S_EXECI)) && r_condex && w_dp_valid
          && (w_funct[0] || w_cmp)) begin
        r_flags[3:2] <= ALUFlags[3:2];
        if (w_cv) r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Next-state and Moore control decode
  always_comb begin
    w_next     = r_state;
    w_pcw      = 1'b0;
    w_irw      = 1'b0;
    w_mw       = 1'b0;
    w_rw       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 2'b00;
    ALUControl = 2'b00;
    MovFlag    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irw     = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_pcw     = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegSrc[0] = (w_op == 2'b10);
        RegSrc[1] = (w_op == 2'b01) && !w_funct[0];
        case (w_op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b01;
        w_next  = w_funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = r_condex;
        w_pcw     = r_condex & w_rd15;
        w_next    = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        RegSrc = 2'b10;
        w_mw   = r_condex;
        w_next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = w_aluctl;
        MovFlag    = w_mov;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        ALUControl = w_aluctl;
        MovFlag    = w_mov;
        w_rw       = r_condex & w_dp_valid & ~w_cmp;
        w_pcw      = r_condex & w_dp_valid & ~w_cmp & w_rd15;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        RegSrc    = 2'b01;
        ALUSrcB   = 2'b01;
        ImmSrc    = 2'b10;
        ResultSrc = 2'b10;
        w_pcw     = r_condex;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are gated by reset so none can pulse while it is held low
  assign PCWrite  = w_pcw & reset;
  assign IRWrite  = w_irw & reset;
  assign MemWrite = w_mw  & reset;
  assign RegWrite = w_rw  & reset;
  assign State    = STATE_W'(r_state);

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: walks instruction sequences and checks controls.
module tb_arm_mc_controller;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, MovFlag;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  State;

  int n_tests = 0;
  int n_fail  = 0;

  arm_mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .MovFlag(MovFlag),
    .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b0;
    Instr    = 20'hE2802;   // ADD R2,R0,#5
    ALUFlags = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", State, 4'd0);
    chk("rst_pcw", 4'(PCWrite), 4'd0);
    chk("rst_irw", 4'(IRWrite), 4'd0);
    chk("rst_rw", 4'(RegWrite), 4'd0);
    chk("rst_mw", 4'(MemWrite), 4'd0);
    chk("rst_srcb", 4'(ALUSrcB), 4'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    // ADD immediate: FETCH, DECODE, EXECI, ALUWB
    chk("add_f_state", State, 4'd0);
    chk("add_f_pcw", 4'(PCWrite), 4'd1);
    chk("add_f_irw", 4'(IRWrite), 4'd1);
    chk("add_f_srca", 4'(ALUSrcA), 4'd1);
    chk("add_f_res", 4'(ResultSrc), 4'd2);
    tick();
    chk("add_d_state", State, 4'd1);
    tick();
    chk("add_e_state", State, 4'd7);
    chk("add_e_srcb", 4'(ALUSrcB), 4'd1);
    chk("add_e_imm", 4'(ImmSrc), 4'd0);
    chk("add_e_ctl", 4'(ALUControl), 4'd0);
    chk("add_e_rw", 4'(RegWrite), 4'd0);
    tick();
    chk("add_wb_state", State, 4'd8);
    chk("add_wb_rw", 4'(RegWrite), 4'd1);
    chk("add_wb_res", 4'(ResultSrc), 4'd0);
    chk("add_wb_pcw", 4'(PCWrite), 4'd0);
    tick();
    chk("add_next_state", State, 4'd0);
    chk("add_next_pcw", 4'(PCWrite), 4'd1);

    // LDR R2,[R0,#96]: 0,1,2,3,4
    Instr = 20'hE5902;
    tick();
    chk("ldr_d_state", State, 4'd1);
    tick();
    chk("ldr_ma_state", State, 4'd2);
    chk("ldr_ma_imm", 4'(ImmSrc), 4'd1);
    chk("ldr_ma_srcb", 4'(ALUSrcB), 4'd1);
    chk("ldr_ma_srca", 4'(ALUSrcA), 4'd0);
    tick();
    chk("ldr_rd_state", State, 4'd3);
    chk("ldr_rd_adr", 4'(AdrSrc), 4'd1);
    tick();
    chk("ldr_wb_state", State, 4'd4);
    chk("ldr_wb_rw", 4'(RegWrite), 4'd1);
    chk("ldr_wb_res", 4'(ResultSrc), 4'd1);
    chk("ldr_wb_pcw", 4'(PCWrite), 4'd0);
    tick();
    chk("ldr_end_state", State, 4'd0);

    // STR R7,[R3,#84]: 0,1,2,5
    Instr = 20'hE5837;
    tick();
    chk("str_d_state", State, 4'd1);
    chk("str_d_regsrc", 4'(RegSrc), 4'd2);
    tick();
    chk("str_ma_state", State, 4'd2);
    chk("str_ma_rw", 4'(RegWrite), 4'd0);
    tick();
    chk("str_wr_state", State, 4'd5);
    chk("str_wr_mw", 4'(MemWrite), 4'd1);
    chk("str_wr_regsrc", 4'(RegSrc), 4'd2);
    chk("str_wr_adr", 4'(AdrSrc), 4'd1);
    chk("str_wr_rw", 4'(RegWrite), 4'd0);
    tick();
    chk("str_end_state", State, 4'd0);
    chk("str_end_mw", 4'(MemWrite), 4'd0);

    // CMP R0,R1 with Z=1 from the ALU
    Instr = 20'hE1500;
    tick();
    tick();
    chk("cmp_e_state", State, 4'd6);
    chk("cmp_e_ctl", 4'(ALUControl), 4'd1);
    chk("cmp_e_srcb", 4'(ALUSrcB), 4'd0);
    ALUFlags = 4'b0100;
    tick();
    ALUFlags = 4'b0000;
    chk("cmp_wb_state", State, 4'd8);
    chk("cmp_wb_rw", 4'(RegWrite), 4'd0);
    chk("cmp_wb_pcw", 4'(PCWrite), 4'd0);
    tick();

    // BEQ taken
    Instr = 20'h0A000;
    tick();
    chk("beq1_d_regsrc", 4'(RegSrc), 4'd1);
    tick();
    chk("beq1_state", State, 4'd9);
    chk("beq1_pcw", 4'(PCWrite), 4'd1);
    chk("beq1_imm", 4'(ImmSrc), 4'd2);
    chk("beq1_srcb", 4'(ALUSrcB), 4'd1);
    tick();
    chk("beq1_end_state", State, 4'd0);

    // CMP giving Z=0, then BEQ not taken and BNE taken
    Instr = 20'hE1500;
    tick();
    tick();
    tick();
    tick();
    Instr = 20'h0A000;
    tick();
    tick();
    chk("beq2_state", State, 4'd9);
    chk("beq2_pcw", 4'(PCWrite), 4'd0);
    tick();
    Instr = 20'h1A000;
    tick();
    tick();
    chk("bne_state", State, 4'd9);
    chk("bne_pcw", 4'(PCWrite), 4'd1);
    tick();

    // MOV PC,#0
    Instr = 20'hE3A0F;
    tick();
    tick();
    chk("mov_e_state", State, 4'd7);
    chk("mov_e_movflag", 4'(MovFlag), 4'd1);
    tick();
    chk("mov_wb_state", State, 4'd8);
    chk("mov_wb_movflag", 4'(MovFlag), 4'd1);
    chk("mov_wb_rw", 4'(RegWrite), 4'd1);
    chk("mov_wb_pcw", 4'(PCWrite), 4'd1);
    tick();

    // Set Z=1 again, then reset in the middle of a store
    Instr = 20'hE1500;
    tick();
    tick();
    ALUFlags = 4'b0100;
    tick();
    ALUFlags = 4'b0000;
    tick();
    Instr = 20'hE5837;
    tick();
    tick();
    tick();
    chk("rstmid_pre_state", State, 4'd5);
    chk("rstmid_pre_mw", 4'(MemWrite), 4'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_mw", 4'(MemWrite), 4'd0);
    chk("rstmid_state", State, 4'd0);
    chk("rstmid_pcw", 4'(PCWrite), 4'd0);
    chk("rstmid_irw", 4'(IRWrite), 4'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstrel_state", State, 4'd0);
    chk("rstrel_irw", 4'(IRWrite), 4'd1);

    // Flags were cleared by reset, so BEQ must not be taken
    Instr = 20'h0A000;
    tick();
    tick();
    chk("beq3_state", State, 4'd9);
    chk("beq3_pcw", 4'(PCWrite), 4'd0);
    tick();
    chk("beq3_end_state", State, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
